// File: rtl/pb_mode_ctrl_if.sv
// Interface for the push-button mode controller: button input, firmware load path
// and the mode/scale/event outputs toward the assist scaling logic.
interface pb_mode_ctrl_if #(
    parameter int SET_W   = 2,
    parameter int SCALE_W = 3
);
    logic               pb;
    logic               mode_ld;
    logic [SET_W-1:0]   mode_in;
    logic [SET_W-1:0]   setting;
    logic [SCALE_W-1:0] scale;
    logic               short_evt;
    logic               long_evt;

    modport master (
        output pb, mode_ld, mode_in,
        input  setting, scale, short_evt, long_evt
    );

    modport slave (
        input  pb, mode_ld, mode_in,
        output setting, scale, short_evt, long_evt
    );
endinterface

// File: rtl/pb_mode_ctrl.sv
// Push-button mode controller: synchronises and debounces the mode button, turns short
// presses into mode advances and long presses into a return to RESET_MODE.
module pb_mode_ctrl #(
    parameter int                            NUM_MODES      = 4,
    parameter int                            SCALE_W        = 3,
    parameter logic [NUM_MODES*SCALE_W-1:0]  SCALE_TBL      = 12'b111_101_011_000,
    parameter int                            RESET_MODE     = 0,
    parameter bit                            WRAP           = 1'b1,
    parameter int                            SYNC_STAGES    = 2,
    parameter int                            DEBOUNCE_CYC   = 16,
    parameter int                            LONG_PRESS_CYC = 64
) (
    input  logic          clk,
    input  logic          rst,
    pb_mode_ctrl_if.slave bus
);
    localparam int SET_W = ($clog2(NUM_MODES) > 1) ? $clog2(NUM_MODES) : 1;
    localparam int CNT_W = ($clog2(LONG_PRESS_CYC) > 1) ? $clog2(LONG_PRESS_CYC) : 1;

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_PRESS_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [SET_W-1:0] MAX_MODE  = SET_W'(NUM_MODES - 1);
    localparam logic [SET_W-1:0] RST_MODE  = SET_W'(RESET_MODE);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        DEB_PRESS = 3'd1,
        PRESSED   = 3'd2,
        LONG_HELD = 3'd3,
        DEB_REL   = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [SET_W-1:0]       setting_q, setting_d;
    logic                   short_pend_q, short_pend_d;
    logic                   short_evt_q, short_evt_d;
    logic                   long_evt_q, long_evt_d;
    logic                   pb_s;

    function automatic logic [SET_W-1:0] advance(input logic [SET_W-1:0] cur);
        logic [SET_W-1:0] nxt;
        if (cur < MAX_MODE) begin
            nxt = cur + SET_W'(1);
        end else if (WRAP) begin
            nxt = {SET_W{1'b0}};
        end else begin
            nxt = cur;
        end
        return nxt;
    endfunction

    assign pb_s   = sync_q[SYNC_STAGES-1];
    assign sync_d = {sync_q[SYNC_STAGES-2:0], bus.pb};

    // Next-state, counter, mode and event logic; load overrides any same-cycle mode action
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        setting_d    = setting_q;
        short_pend_d = short_pend_q;
        short_evt_d  = 1'b0;
        long_evt_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (pb_s) begin
                    state_d = DEB_PRESS;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d = CNT_ZERO;
                end
            end
            DEB_PRESS: begin
                if (!pb_s) begin
                    state_d = IDLE;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = PRESSED;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            PRESSED: begin
                if (cnt_q == LONG_LAST) begin
                    state_d    = LONG_HELD;
                    cnt_d      = CNT_ZERO;
                    setting_d  = RST_MODE;
                    long_evt_d = 1'b1;
                end else if (!pb_s) begin
                    state_d      = DEB_REL;
                    cnt_d        = CNT_ZERO;
                    short_pend_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            LONG_HELD: begin
                if (!pb_s) begin
                    state_d      = DEB_REL;
                    cnt_d        = CNT_ZERO;
                    short_pend_d = 1'b0;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            DEB_REL: begin
                // A release glitch only restarts the stability count
                if (pb_s) begin
                    cnt_d = CNT_ZERO;
                end else if (cnt_q == DEB_LAST) begin
                    state_d      = IDLE;
                    cnt_d        = CNT_ZERO;
                    short_pend_d = 1'b0;
                    if (short_pend_q) begin
                        setting_d   = advance(setting_q);
                        short_evt_d = 1'b1;
                    end else begin
                        setting_d = setting_q;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
        if (bus.mode_ld) begin
            setting_d = (bus.mode_in > MAX_MODE) ? MAX_MODE : bus.mode_in;
        end else begin
            setting_d = setting_d;
        end
    end

    // State, counter, synchroniser and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= CNT_ZERO;
            sync_q       <= {SYNC_STAGES{1'b0}};
            setting_q    <= RST_MODE;
            short_pend_q <= 1'b0;
            short_evt_q  <= 1'b0;
            long_evt_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sync_q       <= sync_d;
            setting_q    <= setting_d;
            short_pend_q <= short_pend_d;
            short_evt_q  <= short_evt_d;
            long_evt_q   <= long_evt_d;
        end
    end

    assign bus.setting   = setting_q;
    assign bus.scale     = SCALE_TBL[setting_q*SCALE_W +: SCALE_W];
    assign bus.short_evt = short_evt_q;
    assign bus.long_evt  = long_evt_q;
endmodule
